// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller: coin codes,
// coin values and the transaction state encoding.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_5    = 2'd1;
  localparam logic [1:0] COIN_10   = 2'd2;
  localparam logic [1:0] COIN_BAD  = 2'd3;

  localparam int CENTS_5  = 5;
  localparam int CENTS_10 = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    RETURN  = 2'd3
  } state_e;

  function automatic logic [3:0] coin_cents(input logic [1:0] code);
    case (code)
      COIN_5:  return 4'(CENTS_5);
      COIN_10: return 4'(CENTS_10);
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_rr_arb.sv
// Two-requester round-robin arbiter; the pointer only flips when both
// slots compete, so a lone requester never disturbs fairness.
module vend_rr_arb
  import vend_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic ptr_b_q, ptr_b_d;

  assign gnt_a_o = en_i && req_a_i && (!req_b_i || !ptr_b_q);
  assign gnt_b_o = en_i && req_b_i && (!req_a_i || ptr_b_q);
  assign ptr_b_d = (en_i && req_a_i && req_b_i) ? !ptr_b_q : ptr_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_b_q <= 1'b0;
    else      ptr_b_q <= ptr_b_d;
  end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction controller: arbitrates two coin slots into one credit
// register, vends at PRICE, returns change one coin per cycle, tracks stock.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE    = 15,
  parameter int STOCK_W  = 4,
  parameter int TIMEOUT  = 64,
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_a_valid,
  input  logic [1:0]          coin_a,
  output logic                coin_a_ready,
  input  logic                coin_b_valid,
  input  logic [1:0]          coin_b,
  output logic                coin_b_ready,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [STOCK_W-1:0]  restock_qty,
  output logic                vend,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic                sold_out,
  output logic                busy
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = CREDIT_W'(PRICE + 5);
  localparam logic [CREDIT_W-1:0] TEN_C      = CREDIT_W'(CENTS_10);
  localparam logic [CREDIT_W-1:0] FIVE_C     = CREDIT_W'(CENTS_5);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [STOCK_W-1:0]  STOCK_MAX  = '1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, acc_credit;
  logic [STOCK_W-1:0]  stock_q, stock_d;
  logic [STOCK_W:0]    stock_sum;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                vend_q, chg_vld_q, reject_q, sold_out_q, busy_q;
  logic [1:0]          chg_coin_q;
  logic                accept_en, gnt_a, gnt_b, accepted, vend_dec;
  logic [1:0]          acc_code;

  assign accept_en = ((state_q == IDLE) || (state_q == COLLECT)) && (stock_q != '0);

  vend_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (accept_en),
    .req_a_i (coin_a_valid),
    .req_b_i (coin_b_valid),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign coin_a_ready = gnt_a;
  assign coin_b_ready = gnt_b;
  assign accepted     = gnt_a || gnt_b;
  assign acc_code     = gnt_b ? coin_b : coin_a;
  assign acc_credit   = credit_q + (accepted ? CREDIT_W'(coin_cents(acc_code)) : '0);

  // A coin landing together with cancel is counted first; reaching PRICE overrides cancel.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    timer_d  = timer_q;
    vend_dec = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (accepted) begin
          credit_d = acc_credit;
          timer_d  = '0;
          if (acc_credit >= PRICE_C)                state_d = VEND;
          else if ((state_q == COLLECT) && cancel)  state_d = RETURN;
          else if (acc_credit != '0)                state_d = COLLECT;
        end else if (state_q == COLLECT) begin
          if (cancel || (timer_q == TIMER_LAST)) state_d = RETURN;
          else                                   timer_d = timer_q + 1'b1;
        end
      end
      VEND: begin
        credit_d = credit_q - PRICE_C;
        vend_dec = 1'b1;
        state_d  = (credit_q == PRICE_C) ? IDLE : RETURN;
      end
      RETURN: begin
        credit_d = credit_q - ((credit_q >= TEN_C) ? TEN_C : FIVE_C);
        if (credit_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stock never underflows: VEND is only reachable with stock > 0.
  assign stock_sum = {1'b0, stock_q} - {{STOCK_W{1'b0}}, vend_dec}
                   + (restock_valid ? {1'b0, restock_qty} : '0);
  assign stock_d   = stock_sum[STOCK_W] ? STOCK_MAX : stock_sum[STOCK_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      stock_q    <= '0;
      timer_q    <= '0;
      vend_q     <= 1'b0;
      chg_vld_q  <= 1'b0;
      chg_coin_q <= COIN_NONE;
      reject_q   <= 1'b0;
      sold_out_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      stock_q    <= stock_d;
      timer_q    <= timer_d;
      vend_q     <= (state_d == VEND);
      chg_vld_q  <= (state_d == RETURN);
      chg_coin_q <= (state_d != RETURN) ? COIN_NONE :
                    (credit_d >= TEN_C) ? COIN_10 : COIN_5;
      reject_q   <= accepted && (acc_code == COIN_BAD);
      sold_out_q <= (stock_d == '0);
      busy_q     <= (state_d == VEND) || (state_d == RETURN);
    end
  end

  assign vend         = vend_q;
  assign change_valid = chg_vld_q;
  assign change_coin  = chg_coin_q;
  assign reject       = reject_q;
  assign credit       = credit_q;
  assign stock        = stock_q;
  assign sold_out     = sold_out_q;
  assign busy         = busy_q;

  credit_bound_a: assert property (@(posedge clk) disable iff (!rst) credit_q <= MAX_CREDIT);

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed vector table, corner-case sequences and
// randomized traffic against a cents-level behavioural model.
module tb_vend_controller;

  localparam int PRICE    = 15;
  localparam int STOCK_W  = 4;
  localparam int TIMEOUT  = 64;
  localparam int CREDIT_W = 6;
  localparam int STOCK_MAX = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic                coin_a_valid, coin_b_valid, cancel, restock_valid;
  logic [1:0]          coin_a, coin_b;
  logic [STOCK_W-1:0]  restock_qty;
  logic                coin_a_ready, coin_b_ready;
  logic                vend, change_valid, reject, sold_out, busy;
  logic [1:0]          change_coin;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock;

  int n_checks = 0;
  int n_err    = 0;

  vend_controller #(.PRICE(PRICE), .STOCK_W(STOCK_W), .TIMEOUT(TIMEOUT), .CREDIT_W(CREDIT_W)) dut (
    .clk(clk), .rst(rst),
    .coin_a_valid(coin_a_valid), .coin_a(coin_a), .coin_a_ready(coin_a_ready),
    .coin_b_valid(coin_b_valid), .coin_b(coin_b), .coin_b_ready(coin_b_ready),
    .cancel(cancel), .restock_valid(restock_valid), .restock_qty(restock_qty),
    .vend(vend), .change_valid(change_valid), .change_coin(change_coin), .reject(reject),
    .credit(credit), .stock(stock), .sold_out(sold_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Behavioural model: a purchase is "collecting" whenever credit is held and
  // nothing is being vended or refunded.
  typedef struct {
    int credit; int stock; int idle;
    bit vending; bit refunding; bit ptrb; bit rej;
  } model_t;

  model_t m;

  function automatic logic [1:0] m_ready(model_t s, logic va, logic vb);
    logic open;
    open = !s.vending && !s.refunding && (s.stock > 0);
    return {open && va && (!vb || !s.ptrb), open && vb && (!va || s.ptrb)};
  endfunction

  function automatic model_t m_next(model_t s, logic va, logic [1:0] ca, logic vb,
                                    logic [1:0] cb, logic cn, logic rv, logic [3:0] rq);
    model_t n;
    logic [1:0] g;
    int code, dec, total;
    n = s;
    dec = 0;
    g = m_ready(s, va, vb);
    n.rej = 1'b0; n.vending = 1'b0; n.refunding = 1'b0;
    if (s.vending) begin
      n.credit = s.credit - PRICE;
      dec = 1;
      n.refunding = (n.credit > 0);
    end else if (s.refunding) begin
      n.credit = s.credit - ((s.credit >= 10) ? 10 : 5);
      n.refunding = (n.credit > 0);
    end else if (g != 2'b00) begin
      code = g[1] ? int'(ca) : int'(cb);
      n.credit = s.credit + ((code == 1) ? 5 : (code == 2) ? 10 : 0);
      n.rej = (code == 3);
      n.idle = 0;
      if (va && vb) n.ptrb = !s.ptrb;
      if (n.credit >= PRICE) n.vending = 1'b1;
      else if ((s.credit > 0) && cn) n.refunding = 1'b1;
    end else if (s.credit > 0) begin
      if (cn || (s.idle == TIMEOUT - 1)) n.refunding = 1'b1;
      else n.idle = s.idle + 1;
    end
    total = s.stock - dec + (rv ? int'(rq) : 0);
    n.stock = (total > STOCK_MAX) ? STOCK_MAX : total;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    else m <= m_next(m, coin_a_valid, coin_a, coin_b_valid, coin_b, cancel, restock_valid, restock_qty);
  end

  typedef struct {
    int va; int ca; int vb; int cb; int cn; int rv; int rq;
    int ra; int rb; int vd; int cv; int cc; int rj; int cr; int st; int bz;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t mk(int va, int ca, int vb, int cb, int cn, int rv, int rq,
                              int ra, int rb, int vd, int cv, int cc, int rj,
                              int cr, int st, int bz);
    vec_t v;
    v = '{va, ca, vb, cb, cn, rv, rq, ra, rb, vd, cv, cc, rj, cr, st, bz};
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int va, input int ca, input int vb, input int cb,
                       input int cn, input int rv, input int rq);
    coin_a_valid  = (va != 0);
    coin_a        = 2'(ca);
    coin_b_valid  = (vb != 0);
    coin_b        = 2'(cb);
    cancel        = (cn != 0);
    restock_valid = (rv != 0);
    restock_qty   = 4'(rq);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_vend"},   int'(vend),         int'(m.vending));
    chk({tag, "_cvld"},   int'(change_valid), int'(m.refunding));
    chk({tag, "_ccoin"},  int'(change_coin),  m.refunding ? ((m.credit >= 10) ? 2 : 1) : 0);
    chk({tag, "_reject"}, int'(reject),       int'(m.rej));
    chk({tag, "_credit"}, int'(credit),       m.credit);
    chk({tag, "_stock"},  int'(stock),        m.stock);
    chk({tag, "_soldout"},int'(sold_out),     int'(m.stock == 0));
    chk({tag, "_busy"},   int'(busy),         int'(m.vending || m.refunding));
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_vend"},    int'(vend),         0);
    chk({tag, "_cvld"},    int'(change_valid), 0);
    chk({tag, "_ccoin"},   int'(change_coin),  0);
    chk({tag, "_reject"},  int'(reject),       0);
    chk({tag, "_credit"},  int'(credit),       0);
    chk({tag, "_stock"},   int'(stock),        0);
    chk({tag, "_soldout"}, int'(sold_out),     1);
    chk({tag, "_busy"},    int'(busy),         0);
    chk({tag, "_ready_a"}, int'(coin_a_ready), 0);
  endtask

  initial begin
    int cnt;
    bit seen;
    logic [1:0] er;
    int r;

    tbl[0]  = mk(0,0,0,0,0,1,3,  0,0, 0,0,0,0,  0,3,0);
    tbl[1]  = mk(1,1,0,0,0,0,0,  1,0, 0,0,0,0,  5,3,0);
    tbl[2]  = mk(1,1,0,0,0,0,0,  1,0, 0,0,0,0, 10,3,0);
    tbl[3]  = mk(1,1,0,0,0,0,0,  1,0, 1,0,0,0, 15,3,1);
    tbl[4]  = mk(0,0,0,0,0,0,0,  0,0, 0,0,0,0,  0,2,0);
    tbl[5]  = mk(1,2,0,0,0,0,0,  1,0, 0,0,0,0, 10,2,0);
    tbl[6]  = mk(0,0,1,1,0,0,0,  0,1, 1,0,0,0, 15,2,1);
    tbl[7]  = mk(0,0,0,0,0,0,0,  0,0, 0,0,0,0,  0,1,0);
    tbl[8]  = mk(1,2,0,0,0,0,0,  1,0, 0,0,0,0, 10,1,0);
    tbl[9]  = mk(1,2,0,0,0,0,0,  1,0, 1,0,0,0, 20,1,1);
    tbl[10] = mk(0,0,0,0,0,0,0,  0,0, 0,1,1,0,  5,0,1);
    tbl[11] = mk(0,0,1,1,0,0,0,  0,0, 0,0,0,0,  0,0,0);
    tbl[12] = mk(0,0,1,1,0,0,0,  0,0, 0,0,0,0,  0,0,0);
    tbl[13] = mk(0,0,1,1,0,1,5,  0,0, 0,0,0,0,  0,5,0);
    tbl[14] = mk(1,1,1,1,0,0,0,  1,0, 0,0,0,0,  5,5,0);
    tbl[15] = mk(1,1,1,1,0,0,0,  0,1, 0,0,0,0, 10,5,0);
    tbl[16] = mk(1,1,1,1,0,0,0,  1,0, 1,0,0,0, 15,5,1);
    tbl[17] = mk(1,1,1,1,0,0,0,  0,0, 0,0,0,0,  0,4,0);
    tbl[18] = mk(0,0,1,1,0,0,0,  0,1, 0,0,0,0,  5,4,0);
    tbl[19] = mk(0,0,0,0,1,0,0,  0,0, 0,1,1,0,  5,4,1);
    tbl[20] = mk(0,0,0,0,0,0,0,  0,0, 0,0,0,0,  0,4,0);
    tbl[21] = mk(1,2,0,0,0,0,0,  1,0, 0,0,0,0, 10,4,0);
    tbl[22] = mk(0,0,0,0,1,0,0,  0,0, 0,1,2,0, 10,4,1);
    tbl[23] = mk(0,0,0,0,0,0,0,  0,0, 0,0,0,0,  0,4,0);
    tbl[24] = mk(1,3,0,0,0,0,0,  1,0, 0,0,0,1,  0,4,0);
    tbl[25] = mk(0,0,0,0,0,0,0,  0,0, 0,0,0,0,  0,4,0);
    tbl[26] = mk(1,1,0,0,0,0,0,  1,0, 0,0,0,0,  5,4,0);
    tbl[27] = mk(1,3,0,0,0,0,0,  1,0, 0,0,0,1,  5,4,0);
    tbl[28] = mk(0,0,0,0,1,0,0,  0,0, 0,1,1,0,  5,4,1);
    tbl[29] = mk(0,0,0,0,0,0,0,  0,0, 0,0,0,0,  0,4,0);
    tbl[30] = mk(0,0,0,0,1,0,0,  0,0, 0,0,0,0,  0,4,0);
    tbl[31] = mk(1,2,0,0,0,0,0,  1,0, 0,0,0,0, 10,4,0);
    tbl[32] = mk(1,1,0,0,1,0,0,  1,0, 1,0,0,0, 15,4,1);
    tbl[33] = mk(0,0,0,0,0,0,0,  0,0, 0,0,0,0,  0,3,0);

    rst = 1'b0;
    drive(1,1,0,0,0,0,0);
    @(negedge clk);
    reset_outputs_chk("reset");
    drive(0,0,0,0,0,0,0);
    rst = 1'b1;

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].va, tbl[i].ca, tbl[i].vb, tbl[i].cb, tbl[i].cn, tbl[i].rv, tbl[i].rq);
      #1;
      chk($sformatf("v%0d_ready_a", i), int'(coin_a_ready), tbl[i].ra);
      chk($sformatf("v%0d_ready_b", i), int'(coin_b_ready), tbl[i].rb);
      tick();
      chk($sformatf("v%0d_vend", i),    int'(vend),         tbl[i].vd);
      chk($sformatf("v%0d_cvld", i),    int'(change_valid), tbl[i].cv);
      chk($sformatf("v%0d_ccoin", i),   int'(change_coin),  tbl[i].cc);
      chk($sformatf("v%0d_reject", i),  int'(reject),       tbl[i].rj);
      chk($sformatf("v%0d_credit", i),  int'(credit),       tbl[i].cr);
      chk($sformatf("v%0d_stock", i),   int'(stock),        tbl[i].st);
      chk($sformatf("v%0d_soldout", i), int'(sold_out),     int'(tbl[i].st == 0));
      chk($sformatf("v%0d_busy", i),    int'(busy),         tbl[i].bz);
    end

    // Idle timeout refund: stock is 3 here.
    drive(1,1,0,0,0,0,0);
    #1 chk("to_ready_a", int'(coin_a_ready), 1);
    tick();
    chk("to_credit", int'(credit), 5);
    drive(0,0,0,0,0,0,0);
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < TIMEOUT + 4 && !seen; k++) begin
      tick();
      cnt++;
      if (change_valid) seen = 1'b1;
    end
    chk("to_seen", int'(seen), 1);
    chk("to_cycles", cnt, TIMEOUT);
    chk("to_coin", int'(change_coin), 1);
    tick();
    chk("to_credit_after", int'(credit), 0);
    chk("to_busy_after", int'(busy), 0);

    // Stock saturation.
    drive(0,0,0,0,0,1,7);
    tick();
    chk("sat_stock10", int'(stock), 10);
    drive(0,0,0,0,0,1,15);
    tick();
    chk("sat_stock15", int'(stock), 15);

    // Asynchronous reset during the first change cycle.
    drive(1,2,0,0,0,0,0);
    tick();
    drive(1,2,0,0,0,0,0);
    tick();
    chk("ar_vend", int'(vend), 1);
    chk("ar_credit20", int'(credit), 20);
    drive(0,0,0,0,0,0,0);
    tick();
    chk("ar_cvld", int'(change_valid), 1);
    chk("ar_credit5", int'(credit), 5);
    #2 rst = 1'b0;
    drive(1,1,0,0,0,0,0);
    #1 reset_outputs_chk("ar_reset");
    tick();
    tick();
    drive(0,0,0,0,0,0,0);
    rst = 1'b1;
    tick();
    chk("ar_post_cvld", int'(change_valid), 0);
    chk("ar_post_credit", int'(credit), 0);
    chk("ar_post_stock", int'(stock), 0);

    // Randomized traffic against the model (model was reset with the DUT).
    drive(0,0,0,0,0,1,6);
    tick();
    chk_model("rnd_init");
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 9);
      coin_a        = (r == 0) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 9);
      coin_b        = (r == 0) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      coin_a_valid  = ($urandom_range(0, 2) == 0);
      coin_b_valid  = ($urandom_range(0, 2) == 0);
      cancel        = ($urandom_range(0, 9) == 0);
      restock_valid = ($urandom_range(0, 11) == 0);
      restock_qty   = 4'($urandom_range(0, 15));
      #1;
      er = m_ready(m, coin_a_valid, coin_b_valid);
      chk("rnd_ready_a", int'(coin_a_ready), int'(er[1]));
      chk("rnd_ready_b", int'(coin_b_ready), int'(er[0]));
      tick();
      chk_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
